// File: rtl/ifq_pkg.sv
// Shared definitions for the instruction fetch queue: widths, the halt opcode and
// the fetch FSM state encoding.
package ifq_pkg;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 8;

   localparam logic [DATA_W-1:0] HLT_OPCODE = 8'hFF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DROP = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/sync_fifo.sv
// DEPTH x WIDTH circular buffer with occupancy count and synchronous clear.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             full;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CNT_W'(DEPTH));
   assign do_push = push && !full && !clear;
   assign do_pop  = pop && !empty && !clear;
   assign count   = count_q;
   assign head    = empty ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
         end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: the head is masked to zero whenever the count is zero.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: walks fetch_pc, issues single outstanding byte reads and queues the
// returned bytes for decode. Optional halt detection is enabled by IFQ_HALT_DETECT_EN.
module instr_fetch_queue
   import ifq_pkg::*;
#(
   parameter int                DEPTH      = 4,
   parameter logic [ADDR_W-1:0] RESET_ADDR = 8'h00
) (
   input  logic              clk,
   input  logic              rst,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_data,
   output logic [DATA_W-1:0] instr,
   output logic              instr_valid,
   input  logic              instr_ready,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_addr,
   output logic [ADDR_W-1:0] fetch_pc
`ifdef IFQ_HALT_DETECT_EN
   ,
   output logic              halted
`endif
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic              mem_req_q, mem_req_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

   logic              fifo_push;
   logic              fifo_pop;
   logic              fifo_clear;
   logic [DATA_W-1:0] fifo_head;
   logic [CNT_W-1:0]  fifo_count;
   logic              fifo_empty;
   logic              response;
   logic              halt_block;

   sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (DATA_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .clear     (fifo_clear),
      .push      (fifo_push),
      .push_data (mem_data),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .count     (fifo_count),
      .empty     (fifo_empty)
   );

   assign response    = mem_req_q && mem_ack;
   assign instr       = fifo_head;
   assign instr_valid = !fifo_empty;
   assign mem_req     = mem_req_q;
   assign mem_addr    = mem_addr_q;
   assign fetch_pc    = fetch_pc_q;

   // Redirect wins over everything except reset: it clears the queue, retargets
   // fetch_pc and turns an outstanding request into one whose data is thrown away.
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      mem_req_d  = mem_req_q;
      mem_addr_d = mem_addr_q;
      fifo_push  = 1'b0;
      fifo_pop   = instr_ready && !fifo_empty && !redirect;
      fifo_clear = redirect;

      case (state_q)
         IDLE: begin
            if (!redirect && (fifo_count < CNT_W'(DEPTH)) && !halt_block) begin
               state_d    = REQ;
               mem_req_d  = 1'b1;
               mem_addr_d = fetch_pc_q;
            end
         end
         REQ: begin
            if (response) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
               if (!redirect) begin
                  fifo_push  = 1'b1;
                  fetch_pc_d = fetch_pc_q + 8'd1;
               end
            end else if (redirect) begin
               state_d = DROP;
            end
         end
         DROP: begin
            if (response) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
            end
         end
         default: begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
         end
      endcase

      if (redirect) begin
         fetch_pc_d = redirect_addr;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_ADDR;
         mem_req_q  <= 1'b0;
         mem_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         mem_req_q  <= mem_req_d;
         mem_addr_q <= mem_addr_d;
      end
   end

`ifdef IFQ_HALT_DETECT_EN
   logic halted_q, halted_d;

   // A queued HLT opcode stops further issue until decode redirects elsewhere.
   always_comb begin
      halted_d = halted_q;
      if (fifo_push && (mem_data == HLT_OPCODE)) begin
         halted_d = 1'b1;
      end
      if (redirect) begin
         halted_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         halted_q <= 1'b0;
      end else begin
         halted_q <= halted_d;
      end
   end

   assign halted     = halted_q;
   assign halt_block = halted_q;
`else
   assign halt_block = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue; program memory returns prog[mem_addr] and
// acks either combinationally from mem_req or from a manually driven strobe.
module tb_instr_fetch_queue;

   logic       clk = 1'b0;
   logic       rst;
   logic       mem_req;
   logic [7:0] mem_addr;
   logic       mem_ack;
   logic [7:0] mem_data;
   logic [7:0] instr;
   logic       instr_valid;
   logic       instr_ready;
   logic       redirect;
   logic [7:0] redirect_addr;
   logic [7:0] fetch_pc;
`ifdef IFQ_HALT_DETECT_EN
   logic       halted;
`endif

   logic       auto_ack;
   logic       manual_ack;
   logic [7:0] prog [256];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   assign mem_ack  = auto_ack ? mem_req : manual_ack;
   assign mem_data = prog[mem_addr];

   instr_fetch_queue #(
      .DEPTH      (4),
      .RESET_ADDR (8'h00)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .mem_req       (mem_req),
      .mem_addr      (mem_addr),
      .mem_ack       (mem_ack),
      .mem_data      (mem_data),
      .instr         (instr),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .redirect      (redirect),
      .redirect_addr (redirect_addr),
      .fetch_pc      (fetch_pc)
`ifdef IFQ_HALT_DETECT_EN
      ,
      .halted        (halted)
`endif
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst         = 1'b1;
      redirect    = 1'b0;
      instr_ready = 1'b0;
      manual_ack  = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_reset;
      auto_ack = 1'b0;
      do_reset();
      checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %b want 0", mem_req); end
      checks++; if (mem_addr !== 8'h00) begin errors++; $display("[TB] FAIL reset_addr: got %h want 00", mem_addr); end
      checks++; if (instr !== 8'h00) begin errors++; $display("[TB] FAIL reset_instr: got %h want 00", instr); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b want 0", instr_valid); end
      checks++; if (fetch_pc !== 8'h00) begin errors++; $display("[TB] FAIL reset_pc: got %h want 00", fetch_pc); end
`ifdef IFQ_HALT_DETECT_EN
      checks++; if (halted !== 1'b0) begin errors++; $display("[TB] FAIL reset_halted: got %b want 0", halted); end
`endif
   endtask

   task automatic test_fill;
      logic [7:0] exp_addr;
      do_reset();
      auto_ack = 1'b1;
      rst      = 1'b0;
      for (int k = 0; k < 4; k++) begin
         exp_addr = 8'(k);
         tick();
         checks++; if (mem_req !== 1'b1) begin errors++; $display("[TB] FAIL fill_req%0d: got %b want 1", k, mem_req); end
         checks++; if (mem_addr !== exp_addr) begin errors++; $display("[TB] FAIL fill_addr%0d: got %h want %h", k, mem_addr, exp_addr); end
         checks++; if (instr_valid !== (k != 0)) begin errors++; $display("[TB] FAIL fill_valid_at_issue%0d: got %b want %b", k, instr_valid, (k != 0)); end
         tick();
         checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL fill_req_drop%0d: got %b want 0", k, mem_req); end
         checks++; if (instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL fill_valid%0d: got %b want 1", k, instr_valid); end
      end
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL full_no_req%0d: got %b want 0", k, mem_req); end
      end
      checks++; if (instr !== 8'h00) begin errors++; $display("[TB] FAIL full_head: got %h want 00", instr); end
      checks++; if (fetch_pc !== 8'h04) begin errors++; $display("[TB] FAIL full_pc: got %h want 04", fetch_pc); end
   endtask

   task automatic test_pop_one;
      int   issues;
      logic prev_req;
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      checks++; if (instr !== 8'h01) begin errors++; $display("[TB] FAIL pop_head: got %h want 01", instr); end
      checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL pop_req_same: got %b want 0", mem_req); end
      issues   = 0;
      prev_req = mem_req;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (mem_req && !prev_req) begin
            issues++;
            checks++; if (mem_addr !== 8'h04) begin errors++; $display("[TB] FAIL pop_addr: got %h want 04", mem_addr); end
         end
         prev_req = mem_req;
      end
      checks++; if (issues !== 1) begin errors++; $display("[TB] FAIL pop_issues: got %0d want 1", issues); end
      checks++; if (fetch_pc !== 8'h05) begin errors++; $display("[TB] FAIL pop_pc: got %h want 05", fetch_pc); end
   endtask

   task automatic test_walk;
      logic [7:0] exp_byte;
      logic [7:0] prev_pc;
      int         seen;
      logic       wrapped;
      exp_byte    = 8'h01;
      seen        = 0;
      wrapped     = 1'b0;
      prev_pc     = fetch_pc;
      instr_ready = 1'b1;
      for (int cyc = 0; cyc < 1200; cyc++) begin
         if (instr_valid) begin
            checks++; if (instr !== exp_byte) begin errors++; $display("[TB] FAIL walk_byte: got %h want %h", instr, exp_byte); end
            exp_byte = exp_byte + 8'd1;
            seen++;
         end
         if (prev_pc == 8'hFF && fetch_pc == 8'h00) wrapped = 1'b1;
         prev_pc = fetch_pc;
         if (seen >= 255) break;
         tick();
      end
      instr_ready = 1'b0;
      checks++; if (seen !== 255) begin errors++; $display("[TB] FAIL walk_count: got %0d want 255", seen); end
      checks++; if (wrapped !== 1'b1) begin errors++; $display("[TB] FAIL walk_pc_wrap: got %b want 1", wrapped); end
   endtask

   task automatic test_delayed_ack;
      do_reset();
      auto_ack = 1'b0;
      rst      = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++; if (mem_req !== 1'b1) begin errors++; $display("[TB] FAIL hold_req%0d: got %b want 1", k, mem_req); end
         checks++; if (mem_addr !== 8'h00) begin errors++; $display("[TB] FAIL hold_addr%0d: got %h want 00", k, mem_addr); end
      end
      manual_ack = 1'b1;
      tick();
      manual_ack = 1'b0;
      checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL delay_req_drop: got %b want 0", mem_req); end
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL delay_valid: got %b want 1", instr_valid); end
      checks++; if (instr !== 8'h00) begin errors++; $display("[TB] FAIL delay_instr: got %h want 00", instr); end
      checks++; if (fetch_pc !== 8'h01) begin errors++; $display("[TB] FAIL delay_pc: got %h want 01", fetch_pc); end
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL delay_single_push: got %b want 0", instr_valid); end
      checks++; if (mem_addr !== 8'h01) begin errors++; $display("[TB] FAIL delay_next_addr: got %h want 01", mem_addr); end
   endtask

   task automatic test_redirect;
      do_reset();
      auto_ack      = 1'b0;
      rst           = 1'b0;
      redirect      = 1'b1;
      redirect_addr = 8'h03;
      tick();
      redirect = 1'b0;
      checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL redir_idle_req: got %b want 0", mem_req); end
      checks++; if (fetch_pc !== 8'h03) begin errors++; $display("[TB] FAIL redir_idle_pc: got %h want 03", fetch_pc); end
      tick();
      manual_ack = 1'b1; tick(); manual_ack = 1'b0; tick();
      manual_ack = 1'b1; tick(); manual_ack = 1'b0; tick();
      checks++; if (mem_addr !== 8'h05 || mem_req !== 1'b1) begin errors++; $display("[TB] FAIL redir_pending: got req=%b addr=%h want req=1 addr=05", mem_req, mem_addr); end
      checks++; if (instr !== 8'h03 || instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL redir_queued: got valid=%b instr=%h want valid=1 instr=03", instr_valid, instr); end
      redirect      = 1'b1;
      redirect_addr = 8'h40;
      instr_ready   = 1'b1;
      tick();
      redirect    = 1'b0;
      instr_ready = 1'b0;
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL redir_flush: got %b want 0", instr_valid); end
      checks++; if (fetch_pc !== 8'h40) begin errors++; $display("[TB] FAIL redir_pc: got %h want 40", fetch_pc); end
      checks++; if (mem_req !== 1'b1 || mem_addr !== 8'h05) begin errors++; $display("[TB] FAIL drop_hold: got req=%b addr=%h want req=1 addr=05", mem_req, mem_addr); end
      tick();
      checks++; if (mem_req !== 1'b1 || mem_addr !== 8'h05) begin errors++; $display("[TB] FAIL drop_hold2: got req=%b addr=%h want req=1 addr=05", mem_req, mem_addr); end
      manual_ack = 1'b1;
      tick();
      manual_ack = 1'b0;
      checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL drop_ack_req: got %b want 0", mem_req); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL drop_discard: got valid=%b instr=%h want valid=0", instr_valid, instr); end
      tick();
      checks++; if (mem_req !== 1'b1 || mem_addr !== 8'h40) begin errors++; $display("[TB] FAIL redir_new_req: got req=%b addr=%h want req=1 addr=40", mem_req, mem_addr); end
      manual_ack = 1'b1;
      tick();
      manual_ack = 1'b0;
      checks++; if (instr_valid !== 1'b1 || instr !== 8'h40) begin errors++; $display("[TB] FAIL redir_new_byte: got valid=%b instr=%h want valid=1 instr=40", instr_valid, instr); end
      checks++; if (fetch_pc !== 8'h41) begin errors++; $display("[TB] FAIL redir_new_pc: got %h want 41", fetch_pc); end
   endtask

   task automatic test_reset_mid;
      do_reset();
      auto_ack = 1'b0;
      rst      = 1'b0;
      tick();
      for (int k = 0; k < 3; k++) begin
         manual_ack = 1'b1; tick(); manual_ack = 1'b0; tick();
      end
      checks++; if (mem_req !== 1'b1 || mem_addr !== 8'h03) begin errors++; $display("[TB] FAIL mid_pending: got req=%b addr=%h want req=1 addr=03", mem_req, mem_addr); end
      checks++; if (instr_valid !== 1'b1 || instr !== 8'h00) begin errors++; $display("[TB] FAIL mid_queued: got valid=%b instr=%h want valid=1 instr=00", instr_valid, instr); end
      rst = 1'b1;
      tick();
      checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_req: got %b want 0", mem_req); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_valid: got %b want 0", instr_valid); end
      checks++; if (fetch_pc !== 8'h00) begin errors++; $display("[TB] FAIL mid_rst_pc: got %h want 00", fetch_pc); end
      checks++; if (mem_addr !== 8'h00 || instr !== 8'h00) begin errors++; $display("[TB] FAIL mid_rst_outs: got addr=%h instr=%h want 00 00", mem_addr, instr); end
      rst        = 1'b0;
      manual_ack = 1'b1;
      tick();
      manual_ack = 1'b0;
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL stale_ack_push: got %b want 0", instr_valid); end
      checks++; if (fetch_pc !== 8'h00) begin errors++; $display("[TB] FAIL stale_ack_pc: got %h want 00", fetch_pc); end
      checks++; if (mem_req !== 1'b1 || mem_addr !== 8'h00) begin errors++; $display("[TB] FAIL stale_ack_issue: got req=%b addr=%h want req=1 addr=00", mem_req, mem_addr); end
   endtask

`ifdef IFQ_HALT_DETECT_EN
   task automatic test_halt;
      do_reset();
      prog[0]  = 8'h10;
      prog[1]  = 8'h20;
      prog[2]  = 8'hFF;
      auto_ack = 1'b1;
      rst      = 1'b0;
      for (int k = 0; k < 5; k++) tick();
      checks++; if (halted !== 1'b0 || mem_addr !== 8'h02) begin errors++; $display("[TB] FAIL halt_early: got halted=%b addr=%h want 0 02", halted, mem_addr); end
      tick();
      checks++; if (halted !== 1'b1) begin errors++; $display("[TB] FAIL halt_set: got %b want 1", halted); end
      checks++; if (fetch_pc !== 8'h03) begin errors++; $display("[TB] FAIL halt_pc: got %h want 03", fetch_pc); end
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL halt_no_req%0d: got %b want 0", k, mem_req); end
      end
      checks++; if (instr !== 8'h10) begin errors++; $display("[TB] FAIL halt_head: got %h want 10", instr); end
      redirect      = 1'b1;
      redirect_addr = 8'h80;
      tick();
      redirect = 1'b0;
      checks++; if (halted !== 1'b0) begin errors++; $display("[TB] FAIL halt_clear: got %b want 0", halted); end
      checks++; if (fetch_pc !== 8'h80) begin errors++; $display("[TB] FAIL halt_redir_pc: got %h want 80", fetch_pc); end
      tick();
      checks++; if (mem_req !== 1'b1 || mem_addr !== 8'h80) begin errors++; $display("[TB] FAIL halt_resume: got req=%b addr=%h want req=1 addr=80", mem_req, mem_addr); end
      prog[0] = 8'h00;
      prog[1] = 8'h01;
      prog[2] = 8'h02;
   endtask
`endif

   initial begin
      rst           = 1'b1;
      redirect      = 1'b0;
      redirect_addr = 8'h00;
      instr_ready   = 1'b0;
      auto_ack      = 1'b0;
      manual_ack    = 1'b0;
      for (int i = 0; i < 256; i++) prog[i] = 8'(i);

      test_reset();
      test_fill();
      test_pop_one();
      test_walk();
      test_delayed_ack();
      test_redirect();
      test_reset_mid();
`ifdef IFQ_HALT_DETECT_EN
      test_halt();
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
